mips_exec_mem_unit: RTL and testbench
=====================================

Name: mips_exec_mem_unit

Overview:
Execute/memory slice of the 8-bit teaching MIPS core.
- An 8-bit ALU computes a result that doubles as the data-memory address.
- A small data memory is read and written at that address.
- A clock divider generates the slow "step" clock (about 1 s) that drives the program counter.
- All logic sits on the single board clock; the slow clock is a derived output, not a second clock domain inside this block.

Parameters:
- DW, 8, datapath width (ALU operands, memory word, address source).
- DEPTH, 32, number of data-memory words. Power of two; index = low log2(DEPTH) bits of the address.
- HALF_COUNT, 50000000, board-clock cycles per half period of Slow_Clk. Must be ≥1.

Ports:
- Clk, input, 1: board clock; all state updates on the rising edge.
- Clear, input, 1: reset, synchronous, active-low.
- ALUOp, input, 1: 0 = add, 1 = subtract.
- Data1, input, DW: ALU operand A.
- Data2, input, DW: ALU operand B (register or sign-extended immediate, muxed upstream).
- Write_Data, input, DW: store data.
- MemRead, input, 1: load enable.
- MemWrite, input, 1: store enable.
- ALU_Result, output, DW: ALU result and memory address.
- Zero, output, 1: high when ALU_Result == 0.
- Read_Data, output, DW: load data.
- Slow_Clk, output, 1: divided clock, 50% duty.
- Slow_Tick, output, 1: one-Clk-cycle pulse on each Slow_Clk rising transition.

Behaviour:

ALU (combinational):
- ALUOp=0: ALU_Result = Data1 + Data2, modulo 2^DW.
- ALUOp=1: ALU_Result = Data1 − Data2, modulo 2^DW (two's complement wrap).
- No carry or overflow outputs.
- ALU_Result and Zero are unaffected by Clear.

Data memory:
- DEPTH×DW register array; index = ALU_Result[log2(DEPTH)−1:0]. Higher address bits are ignored, so addresses wrap.
- Read is combinational: Read_Data = mem[index] when MemRead=1, else 0.
- Write is synchronous: on a rising Clk with Clear=1 and MemWrite=1, mem[index] ← Write_Data.
- MemRead and MemWrite together on the same address: Read_Data shows the old contents in that cycle and the new value from the next cycle.
- Reset (Clear=0 at a rising edge): every word is loaded with its own index, mem[i] = i, truncated to DW. Writes are suppressed during that edge.

Clock divider:
- 32-bit counter cnt.
- On reset: cnt=0, Slow_Clk=0, Slow_Tick=0.
- Otherwise at each edge:
  - If cnt == HALF_COUNT−1: cnt ← 0, Slow_Clk toggles, and Slow_Tick ← 1 only when Slow_Clk goes 0→1.
  - Else: cnt++ and Slow_Tick ← 0.
- Slow_Clk period = 2·HALF_COUNT Clk cycles.
- The first Slow_Clk rise occurs HALF_COUNT edges after reset release.
- Reset asserted mid-count restarts the divider from the reset state at that edge.
- Slow_Tick is registered and coincides with the cycle in which Slow_Clk first reads 1.

Decomposition:
- Shared package mips_pkg holds:
  - DW = 8;
  - ALU_ADD = 1'b0;
  - ALU_SUB = 1'b1.
  - The core's other blocks reuse these.
- One sub-module: mips_clk_divider (parameter HALF_COUNT; ports Clk, Clear, Slow_Clk, Slow_Tick).
- The ALU and memory array stay inline in mips_exec_mem_unit.

Test Plan:
1. Reset, then MemRead=1 with ALUOp=0, Data1=0, Data2=5 → ALU_Result=5, Read_Data=5. With Data2=37 (DEPTH=32) → index 5, Read_Data=5.
2. ALU arithmetic:
   - ALUOp=0, 200+100 → ALU_Result=44.
   - ALUOp=1, 3−5 → 254, Zero=0.
   - ALUOp=1, 7−7 → 0, Zero=1.
3. Store then load at address 9:
   - MemWrite=1, Write_Data=0xA5 for one edge.
   - In that cycle with MemRead=1, Read_Data=9.
   - Next cycle, MemWrite=0 → Read_Data=0xA5.
   - With MemRead=0 → Read_Data=0.
4. Write suppression under reset: hold Clear=0 with MemWrite=1, Write_Data=0xFF at address 3 → after release, mem[3] reads 3.
5. Divider with HALF_COUNT=3, Clear released before edge 0 (edge 0 = first rising edge with Clear=1):
   - Slow_Clk goes 1 after edge 2, 0 after edge 5, 1 after edge 8.
   - Slow_Tick is high only during the cycles after edges 2 and 8.
6. Reset mid-count: assert Clear=0 at edge 1 of a period, release → cnt restarts. Next Slow_Clk toggle occurs exactly 3 edges after release, and Slow_Clk=0 during the reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 8-bit teaching MIPS core.
//   DW      : datapath width used across the core
//   ALU_ADD : ALUOp encoding for addition
//   ALU_SUB : ALUOp encoding for subtraction
package mips_pkg;
    localparam int DW = 8;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;
endpackage

// File: rtl/mips_clk_divider.sv
// Board-clock divider producing the slow step clock for the program counter.
//   Clk       : board clock (rising edge)
//   Clear     : synchronous active-low reset
//   Slow_Clk  : divided clock, 50% duty, period 2*HALF_COUNT Clk cycles
//   Slow_Tick : one-Clk pulse in the first cycle Slow_Clk reads 1
module mips_clk_divider #(
    parameter int HALF_COUNT = 50000000
) (
    input  logic Clk,
    input  logic Clear,
    output logic Slow_Clk,
    output logic Slow_Tick
);
    localparam logic [31:0] LAST = 32'(HALF_COUNT - 1);

    logic [31:0] cnt;
    logic        slow_q;
    logic        tick_q;

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            cnt    <= '0;
            slow_q <= 1'b0;
            tick_q <= 1'b0;
        end else if (cnt == LAST) begin
            cnt    <= '0;
            slow_q <= ~slow_q;
            // Pulse only on the 0->1 transition of the slow clock.
            tick_q <= ~slow_q;
        end else begin
            cnt    <= cnt + 32'd1;
            tick_q <= 1'b0;
        end
    end

    assign Slow_Clk  = slow_q;
    assign Slow_Tick = tick_q;
endmodule

// File: rtl/mips_exec_mem_unit.sv
// Execute/memory slice: 8-bit add/sub ALU whose result addresses a small
// data memory, plus the slow step-clock divider.
//   Clk, Clear        : board clock, synchronous active-low reset
//   ALUOp             : 0 = add, 1 = subtract
//   Data1, Data2      : ALU operands
//   Write_Data        : store data
//   MemRead, MemWrite : load / store enables
//   ALU_Result, Zero  : ALU result (also memory address) and zero flag
//   Read_Data         : load data (0 when MemRead is low)
//   Slow_Clk, Slow_Tick : divided clock and its rising-edge pulse
module mips_exec_mem_unit
    import mips_pkg::*;
#(
    parameter int DW         = mips_pkg::DW,
    parameter int DEPTH      = 32,
    parameter int HALF_COUNT = 50000000
) (
    input  logic          Clk,
    input  logic          Clear,
    input  logic          ALUOp,
    input  logic [DW-1:0] Data1,
    input  logic [DW-1:0] Data2,
    input  logic [DW-1:0] Write_Data,
    input  logic          MemRead,
    input  logic          MemWrite,
    output logic [DW-1:0] ALU_Result,
    output logic          Zero,
    output logic [DW-1:0] Read_Data,
    output logic          Slow_Clk,
    output logic          Slow_Tick
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] idx;

    // ALU: wraps modulo 2^DW, no carry/overflow reporting.
    always_comb begin
        ALU_Result = Data1 + Data2;
        if (ALUOp == ALU_SUB) ALU_Result = Data1 - Data2;
    end

    assign Zero = (ALU_Result == '0);

    // High address bits are dropped so addresses alias modulo DEPTH.
    assign idx = ALU_Result[AW-1:0];

    assign Read_Data = MemRead ? mem[idx] : '0;

    // Reset preloads mem[i] = i so loads are observable straight out of reset;
    // the reset branch takes priority, which also blocks any store that edge.
    always_ff @(posedge Clk) begin
        if (!Clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
        end else if (MemWrite) begin
            mem[idx] <= Write_Data;
        end
    end

    mips_clk_divider #(
        .HALF_COUNT(HALF_COUNT)
    ) u_div (
        .Clk      (Clk),
        .Clear    (Clear),
        .Slow_Clk (Slow_Clk),
        .Slow_Tick(Slow_Tick)
    );
endmodule

// File: tb/tb_mips_exec_mem_unit.sv
module tb_mips_exec_mem_unit;
    logic       Clk = 1'b0;
    logic       Clear;
    logic       ALUOp;
    logic [7:0] Data1, Data2, Write_Data;
    logic       MemRead, MemWrite;
    logic [7:0] ALU_Result, Read_Data;
    logic       Zero, Slow_Clk, Slow_Tick;

    int checks = 0;
    int fails  = 0;

    mips_exec_mem_unit #(.DW(8), .DEPTH(32), .HALF_COUNT(3)) dut (
        .Clk       (Clk),
        .Clear     (Clear),
        .ALUOp     (ALUOp),
        .Data1     (Data1),
        .Data2     (Data2),
        .Write_Data(Write_Data),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALU_Result(ALU_Result),
        .Zero      (Zero),
        .Read_Data (Read_Data),
        .Slow_Clk  (Slow_Clk),
        .Slow_Tick (Slow_Tick)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Clear = 1'b0; ALUOp = 1'b0; Data1 = 8'd0; Data2 = 8'd5;
        Write_Data = 8'd0; MemRead = 1'b1; MemWrite = 1'b0;
        tick();
        checks++;
        if (Slow_Clk !== 1'b0 || Slow_Tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_div: got clk=%b tick=%b want 0 0", Slow_Clk, Slow_Tick);
        end
        Clear = 1'b1;
        #1;
        checks++;
        if (ALU_Result !== 8'd5 || Read_Data !== 8'd5) begin
            fails++;
            $display("FAIL reset_mem5: got alu=%0d rd=%0d want 5 5", ALU_Result, Read_Data);
        end
        Data2 = 8'd37;
        #1;
        checks++;
        if (ALU_Result !== 8'd37 || Read_Data !== 8'd5) begin
            fails++;
            $display("FAIL reset_wrap37: got alu=%0d rd=%0d want 37 5", ALU_Result, Read_Data);
        end
        Data2 = 8'd31;
        #1;
        checks++;
        if (Read_Data !== 8'd31) begin
            fails++;
            $display("FAIL reset_mem31: got rd=%0d want 31", Read_Data);
        end
    endtask

    task automatic test_alu();
        ALUOp = 1'b0; Data1 = 8'd200; Data2 = 8'd100;
        #1;
        checks++;
        if (ALU_Result !== 8'd44 || Zero !== 1'b0) begin
            fails++;
            $display("FAIL alu_add_wrap: got %0d z=%b want 44 z=0", ALU_Result, Zero);
        end
        ALUOp = 1'b1; Data1 = 8'd3; Data2 = 8'd5;
        #1;
        checks++;
        if (ALU_Result !== 8'd254 || Zero !== 1'b0) begin
            fails++;
            $display("FAIL alu_sub_neg: got %0d z=%b want 254 z=0", ALU_Result, Zero);
        end
        ALUOp = 1'b1; Data1 = 8'd7; Data2 = 8'd7;
        #1;
        checks++;
        if (ALU_Result !== 8'd0 || Zero !== 1'b1) begin
            fails++;
            $display("FAIL alu_sub_zero: got %0d z=%b want 0 z=1", ALU_Result, Zero);
        end
        ALUOp = 1'b0; Data1 = 8'd128; Data2 = 8'd128;
        #1;
        checks++;
        if (ALU_Result !== 8'd0 || Zero !== 1'b1) begin
            fails++;
            $display("FAIL alu_add_zero: got %0d z=%b want 0 z=1", ALU_Result, Zero);
        end
    endtask

    task automatic test_store_load();
        ALUOp = 1'b0; Data1 = 8'd9; Data2 = 8'd0;
        Write_Data = 8'hA5; MemWrite = 1'b1; MemRead = 1'b1;
        #1;
        checks++;
        if (Read_Data !== 8'd9) begin
            fails++;
            $display("FAIL store_old: got %0h want 09", Read_Data);
        end
        tick();
        MemWrite = 1'b0;
        #1;
        checks++;
        if (Read_Data !== 8'hA5) begin
            fails++;
            $display("FAIL store_new: got %0h want a5", Read_Data);
        end
        MemRead = 1'b0;
        #1;
        checks++;
        if (Read_Data !== 8'h00) begin
            fails++;
            $display("FAIL read_disabled: got %0h want 00", Read_Data);
        end
        // 41 aliases to index 9.
        MemRead = 1'b1; Data1 = 8'd41;
        #1;
        checks++;
        if (Read_Data !== 8'hA5) begin
            fails++;
            $display("FAIL load_alias41: got %0h want a5", Read_Data);
        end
        Data1 = 8'd10;
        #1;
        checks++;
        if (Read_Data !== 8'd10) begin
            fails++;
            $display("FAIL neighbour10: got %0h want 0a", Read_Data);
        end
    endtask

    task automatic test_write_suppress();
        Clear = 1'b0; ALUOp = 1'b0; Data1 = 8'd3; Data2 = 8'd0;
        Write_Data = 8'hFF; MemWrite = 1'b1; MemRead = 1'b1;
        tick();
        tick();
        Clear = 1'b1; MemWrite = 1'b0;
        #1;
        checks++;
        if (Read_Data !== 8'd3) begin
            fails++;
            $display("FAIL write_suppress: got %0h want 03", Read_Data);
        end
        // Reset also restored the earlier store at 9.
        Data1 = 8'd9;
        #1;
        checks++;
        if (Read_Data !== 8'd9) begin
            fails++;
            $display("FAIL reset_restore9: got %0h want 09", Read_Data);
        end
    endtask

    task automatic test_divider();
        // Expected after edge k (k = 0..9), HALF_COUNT = 3.
        logic [9:0] exp_clk  = 10'b11_0001_1100;
        logic [9:0] exp_tick = 10'b01_0000_0100;
        Clear = 1'b0;
        tick();
        Clear = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (Slow_Clk !== exp_clk[k] || Slow_Tick !== exp_tick[k]) begin
                fails++;
                $display("FAIL div_edge%0d: got clk=%b tick=%b want %b %b",
                         k, Slow_Clk, Slow_Tick, exp_clk[k], exp_tick[k]);
            end
        end
    endtask

    task automatic test_reset_midcount();
        Clear = 1'b0;
        tick();
        Clear = 1'b1;
        // Edges 0..3: Slow_Clk rises after edge 2, cnt=1 after edge 3.
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (Slow_Clk !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: got clk=%b want 1", Slow_Clk);
        end
        Clear = 1'b0;
        tick();
        checks++;
        if (Slow_Clk !== 1'b0 || Slow_Tick !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got clk=%b tick=%b want 0 0", Slow_Clk, Slow_Tick);
        end
        Clear = 1'b1;
        tick();
        tick();
        checks++;
        if (Slow_Clk !== 1'b0) begin
            fails++;
            $display("FAIL mid_early: got clk=%b want 0 after 2 edges", Slow_Clk);
        end
        tick();
        checks++;
        if (Slow_Clk !== 1'b1 || Slow_Tick !== 1'b1) begin
            fails++;
            $display("FAIL mid_toggle: got clk=%b tick=%b want 1 1", Slow_Clk, Slow_Tick);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_store_load();
        test_write_suppress();
        test_divider();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
